// File: rtl/fp_div_pkg.sv
// Shared types and constants for the Newton-Raphson floating-point divider:
// FSM states, reciprocal seed constants and the normal-path latency.
package fp_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    ITER_MUL,
    ITER_SUB,
    QMUL,
    NORM,
    DONE
  } state_t;

  // Round-down fixed-point value of num/17 with frac fraction bits
  function automatic logic [127:0] seed_div17(input int unsigned num, input int unsigned frac);
    return (128'(num) << frac) / 128'd17;
  endfunction

  function automatic logic [127:0] seed_c48(input int unsigned frac);
    return seed_div17(48, frac);
  endfunction

  function automatic logic [127:0] seed_c32(input int unsigned frac);
    return seed_div17(32, frac);
  endfunction

  function automatic int unsigned nr_latency(input int unsigned iters);
    return 2 * iters + 4;
  endfunction

endpackage

// File: rtl/fp_div_mul.sv
// Unsigned fixed-point multiplier: full product shifted right by FRAC and
// truncated back to the operand width.
module fp_div_mul #(
  parameter int unsigned W    = 29,
  parameter int unsigned FRAC = 27
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] prod_c
);

  localparam int unsigned PW = 2 * W;

  assign prod_c = W'((PW'(a) * PW'(b)) >> FRAC);

endmodule

// File: rtl/fp_nr_divider.sv
// Iterative floating-point divider using a Newton-Raphson reciprocal and one
// shared multiplier. Define FP_DIV_SPECIAL_EN for zero/inf/NaN fast handling.
module fp_nr_divider
  import fp_div_pkg::*;
#(
  parameter int unsigned EXP_W    = 8,
  parameter int unsigned MAN_W    = 23,
  parameter int unsigned NR_ITERS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   exception
);

  localparam int unsigned XLEN = 1 + EXP_W + MAN_W;
  localparam int unsigned F    = MAN_W + 4;
  localparam int unsigned W    = F + 2;
  localparam int unsigned EW   = EXP_W + 2;

  localparam logic [W-1:0] C48    = W'(seed_c48(F));
  localparam logic [W-1:0] C32    = W'(seed_c32(F));
  localparam logic [W-1:0] TWO    = W'(2) << F;
  localparam logic [W-1:0] RND_HI = W'(1) << (F - MAN_W);
  localparam logic [W-1:0] RND_LO = W'(1) << (F - MAN_W - 1);
  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZERO = '0;

  state_t               state;
  logic [2:0]           iter;
  logic [W-1:0]         d_r, ma_r, x_r, t_r, q_r;
  logic                 sign_r, zero_r, bypass_r;
  logic [EXP_W-1:0]     ea_r, eb_r;
  logic [MAN_W-1:0]     man_r;
  logic signed [EW-1:0] exp_r;

  logic [W-1:0]         mul_a, mul_b, mul_c;
  logic [W-1:0]         q_rnd;
  logic signed [EW-1:0] exp_base;
  logic                 a_zero_c, sign_c;

  assign a_zero_c = (A[XLEN-2:MAN_W] == '0);
  assign sign_c   = A[XLEN-1] ^ B[XLEN-1];

  // Half-ulp bias compensates the NR reciprocal approaching from below
  assign q_rnd    = q_r + (q_r[F+1] ? RND_HI : RND_LO);
  assign exp_base = $signed(EW'(ea_r)) - $signed(EW'(eb_r)) + BIAS;

  // Operand steering for the single shared multiplier
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      SEED:     begin mul_a = C32;  mul_b = d_r;       end
      ITER_MUL: begin mul_a = d_r;  mul_b = x_r;       end
      ITER_SUB: begin mul_a = x_r;  mul_b = TWO - t_r; end
      QMUL:     begin mul_a = ma_r; mul_b = x_r;       end
      default:  ;
    endcase
  end

  fp_div_mul #(.W(W), .FRAC(F)) u_mul (
    .a      (mul_a),
    .b      (mul_b),
    .prod_c (mul_c)
  );

`ifdef FP_DIV_SPECIAL_EN
  logic            a_emax, b_emax, a_inf, b_inf, a_nan, b_nan, b_zero;
  logic            special_hit_c, special_exc_c;
  logic [XLEN-1:0] special_res_c;

  assign a_emax = &A[XLEN-2:MAN_W];
  assign b_emax = &B[XLEN-2:MAN_W];
  assign a_inf  = a_emax && (A[MAN_W-1:0] == '0);
  assign b_inf  = b_emax && (B[MAN_W-1:0] == '0);
  assign a_nan  = a_emax && (A[MAN_W-1:0] != '0);
  assign b_nan  = b_emax && (B[MAN_W-1:0] != '0);
  assign b_zero = (B[XLEN-2:MAN_W] == '0);

  always_comb begin
    special_hit_c = 1'b1;
    special_exc_c = 1'b0;
    special_res_c = {sign_c, {(XLEN-1){1'b0}}};
    if (a_nan || b_nan || (a_zero_c && b_zero) || (a_inf && b_inf)) begin
      special_res_c = {sign_c, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      special_exc_c = 1'b1;
    end else if (b_zero) begin
      special_res_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      special_exc_c = 1'b1;
    end else if (a_zero_c || b_inf) begin
      special_res_c = {sign_c, {(XLEN-1){1'b0}}};
    end else if (a_inf) begin
      special_res_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      special_hit_c = 1'b0;
    end
  end
`else
  assign exception = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
`ifdef FP_DIV_SPECIAL_EN
      exception <= 1'b0;
`endif
      iter      <= '0;
      d_r       <= '0;
      ma_r      <= '0;
      x_r       <= '0;
      t_r       <= '0;
      q_r       <= '0;
      sign_r    <= 1'b0;
      zero_r    <= 1'b0;
      bypass_r  <= 1'b0;
      ea_r      <= '0;
      eb_r      <= '0;
      man_r     <= '0;
      exp_r     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready  <= 1'b0;
          overflow  <= 1'b0;
          underflow <= 1'b0;
          sign_r    <= sign_c;
          zero_r    <= a_zero_c;
          bypass_r  <= 1'b0;
          ea_r      <= A[XLEN-2:MAN_W];
          eb_r      <= B[XLEN-2:MAN_W];
          d_r       <= {2'b00, 1'b1, B[MAN_W-1:0], 3'b000};
          ma_r      <= {2'b01, A[MAN_W-1:0], 4'b0000};
          iter      <= '0;
          state     <= SEED;
`ifdef FP_DIV_SPECIAL_EN
          exception <= special_exc_c;
          if (special_hit_c) begin
            result   <= special_res_c;
            bypass_r <= 1'b1;
            state    <= DONE;
          end
`endif
        end
        SEED: begin
          x_r   <= C48 - mul_c;
          state <= ITER_MUL;
        end
        ITER_MUL: begin
          t_r   <= mul_c;
          state <= ITER_SUB;
        end
        ITER_SUB: begin
          x_r  <= mul_c;
          iter <= iter + 3'd1;
          state <= (iter == 3'(NR_ITERS - 1)) ? QMUL : ITER_MUL;
        end
        QMUL: begin
          q_r   <= mul_c;
          state <= NORM;
        end
        NORM: begin
          if (q_rnd[F+1]) begin
            man_r <= MAN_W'(q_rnd >> (F - MAN_W + 1));
            exp_r <= exp_base;
          end else begin
            man_r <= MAN_W'(q_rnd >> (F - MAN_W));
            exp_r <= exp_base - EW'(1);
          end
          state <= DONE;
        end
        DONE: begin
          // First DONE cycle packs and saturates; later cycles wait for the sink
          if (!out_valid) begin
            out_valid <= 1'b1;
            if (!bypass_r) begin
              if (zero_r) begin
                result <= {sign_r, {(XLEN-1){1'b0}}};
              end else if (exp_r >= EMAX) begin
                result   <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                overflow <= 1'b1;
              end else if (exp_r <= EZERO) begin
                result    <= {sign_r, {(XLEN-1){1'b0}}};
                underflow <= 1'b1;
              end else begin
                result <= {sign_r, exp_r[EXP_W-1:0], man_r};
              end
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_nr_divider.sv
// Directed self-checking bench for fp_nr_divider (single precision defaults).
module tb_fp_nr_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow, underflow, exception;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_nr_divider dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .exception (exception)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one operand pair and scramble the inputs right after acceptance
  task automatic start_div(input string tag, input logic [31:0] av, input logic [31:0] bv);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 32'h0; b = 32'h0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_res, input logic [31:0] exp_alt,
                         input logic exp_ovf, input logic exp_unf, input logic exp_exc,
                         input int exp_lat);
    int lat;
    start_div(tag, av, bv);
    wait_out(lat);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (exp_res === exp_alt)
      check({tag, "_result"}, 64'(result), 64'(exp_res));
    else
      check({tag, "_result_in_set"}, 64'(result === exp_res || result === exp_alt), 64'd1);
    check({tag, "_overflow"},  64'(overflow),  64'(exp_ovf));
    check({tag, "_underflow"}, 64'(underflow), 64'(exp_unf));
    check({tag, "_exception"}, 64'(exception), 64'(exp_exc));
    drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 32'h0; b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    64'(result),    64'd0);
    check("rst_overflow",  64'(overflow),  64'd0);
    check("rst_underflow", 64'(underflow), 64'd0);
    check("rst_exception", 64'(exception), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Main function, sign handling and exponent boundaries
    run_div("div6_2",   32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 0, 0, 0, 10);
    run_div("third",    32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 32'h3EAAAAAB, 0, 0, 0, 10);
    run_div("neg6_2",   32'hC0C00000, 32'h40000000, 32'hC0400000, 32'hC0400000, 0, 0, 0, 10);
    run_div("one_one",  32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 0, 0, 10);
    run_div("max_norm", 32'h7F000000, 32'h3F800000, 32'h7F000000, 32'h7F000000, 0, 0, 0, 10);
    run_div("min_norm", 32'h00800000, 32'h3F800000, 32'h00800000, 32'h00800000, 0, 0, 0, 10);
    run_div("ovf",      32'h7F000000, 32'h3E800000, 32'h7F800000, 32'h7F800000, 1, 0, 0, 10);
    run_div("neg_ovf",  32'hFF000000, 32'h3E800000, 32'hFF800000, 32'hFF800000, 1, 0, 0, 10);
    run_div("unf",      32'h00800000, 32'h4B000000, 32'h00000000, 32'h00000000, 0, 1, 0, 10);
    run_div("unf_edge", 32'h00800000, 32'h40000000, 32'h00000000, 32'h00000000, 0, 1, 0, 10);

`ifdef FP_DIV_SPECIAL_EN
    run_div("neg_div0", 32'hBF800000, 32'h00000000, 32'hFF800000, 32'hFF800000, 0, 0, 1, 1);
    run_div("nan_in",   32'h7FC00000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 0, 0, 1, 1);
    run_div("zero_div", 32'h00000000, 32'h40000000, 32'h00000000, 32'h00000000, 0, 0, 0, 1);
    run_div("x_inf",    32'hC0000000, 32'h7F800000, 32'h80000000, 32'h80000000, 0, 0, 0, 1);
`endif

    // Back-pressure: result held, nothing new accepted while out_ready is low
    start_div("stall", 32'h40C00000, 32'h40000000);
    wait_out(lat);
    check("stall_latency", 64'(lat), 64'd10);
    in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_result",    64'(result),    64'h40400000);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready",  64'(in_ready),  64'd0);
    end
    in_valid = 1'b0;
    drain("stall");
    check("stall_ready_back", 64'(in_ready), 64'd1);

    // Reset in the middle of a division abandons it silently
    start_div("abort", 32'h3F800000, 32'h40400000);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_output", 64'(seen), 64'd0);
    run_div("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 0, 0, 0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
